// File: rtl/uzed_led_pkg.sv
// Shared types and constants for the PL LED sequencer.
// Optional feature macro: LED_GAMMA_EN (squared duty in BREATHE mode).
package uzed_led_pkg;

    typedef enum logic [1:0] {
        BINARY  = 2'd0,
        SCAN    = 2'd1,
        BREATHE = 2'd2,
        STATIC  = 2'd3
    } led_mode_t;

    localparam int LED_COUNT = 8;

    localparam logic [2:0] SCAN_POS_FIRST = 3'd0;
    localparam logic [2:0] SCAN_POS_LAST  = 3'(LED_COUNT - 1);

endpackage

// File: rtl/uzed_led_pwm.sv
// Free-running PWM counter and duty comparator for the breathe pattern.
// LED_GAMMA_EN selects a squared (gamma-like) effective duty.
module uzed_led_pwm #(
    parameter int PWM_BITS = 8
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                clear_i,
    input  logic [PWM_BITS-1:0] duty_i,
    output logic                on_o
);

    logic [PWM_BITS-1:0] cnt_q;
    logic [PWM_BITS-1:0] cnt_d;
    logic [PWM_BITS-1:0] duty_eff;

    assign cnt_d = clear_i ? '0 : cnt_q + 1'b1;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

`ifdef LED_GAMMA_EN
    logic [2*PWM_BITS-1:0] duty_sq;

    assign duty_sq  = {{PWM_BITS{1'b0}}, duty_i} * {{PWM_BITS{1'b0}}, duty_i};
    assign duty_eff = duty_sq[2*PWM_BITS-1:PWM_BITS];
`else
    assign duty_eff = duty_i;
`endif

    assign on_o = (cnt_q < duty_eff);

endmodule

// File: rtl/uzed_led_sequencer.sv
// Step-ticked LED pattern sequencer with valid/ready mode changes.
// Build option LED_GAMMA_EN squares the breathe duty inside uzed_led_pwm.
module uzed_led_sequencer
    import uzed_led_pkg::*;
#(
    parameter int unsigned STEP_DIV    = 25000000,
    parameter int          PWM_BITS    = 8,
    parameter int          BREATHE_INC = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 locked,
    input  logic                 mode_valid,
    output logic                 mode_ready,
    input  logic [1:0]           mode_sel,
    input  logic [LED_COUNT-1:0] mode_pattern,
    output logic [LED_COUNT-1:0] led,
    output logic                 heartbeat
);

    localparam logic [31:0]       PRESC_LAST = 32'(STEP_DIV - 1);
    localparam logic [PWM_BITS:0] DUTY_MAX   = {1'b0, {PWM_BITS{1'b1}}};
    localparam logic [PWM_BITS:0] DUTY_INC   = (PWM_BITS + 1)'(BREATHE_INC);

    logic [31:0]           presc_q, presc_d;
    led_mode_t             mode_q, mode_d;
    led_mode_t             pmode_q, pmode_d;
    logic                  pend_q, pend_d;
    logic [LED_COUNT-1:0]  ppat_q, ppat_d;
    logic [LED_COUNT-1:0]  spat_q, spat_d;
    logic                  ready_q, ready_d;
    logic                  hb_q, hb_d;
    logic [LED_COUNT-1:0]  led_q, led_d;
    logic [7:0]            count8_q, count8_d;
    logic [2:0]            pos_q, pos_d;
    logic                  dir_q, dir_d;
    logic [PWM_BITS-1:0]   duty_q, duty_d;
    logic [PWM_BITS:0]     duty_up;
    logic                  step_tick;
    logic                  pwm_on;

    assign step_tick = (presc_q == PRESC_LAST);
    assign duty_up   = {1'b0, duty_q} + DUTY_INC;

    uzed_led_pwm #(
        .PWM_BITS (PWM_BITS)
    ) u_pwm (
        .clk     (clk),
        .reset_n (reset_n),
        .clear_i (!locked),
        .duty_i  (duty_q),
        .on_o    (pwm_on)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            presc_q  <= '0;
            mode_q   <= BINARY;
            pmode_q  <= BINARY;
            pend_q   <= 1'b0;
            ppat_q   <= '0;
            spat_q   <= '0;
            ready_q  <= 1'b1;
            hb_q     <= 1'b0;
            led_q    <= '0;
            count8_q <= '0;
            pos_q    <= SCAN_POS_FIRST;
            dir_q    <= 1'b0;
            duty_q   <= '0;
        end else begin
            presc_q  <= presc_d;
            mode_q   <= mode_d;
            pmode_q  <= pmode_d;
            pend_q   <= pend_d;
            ppat_q   <= ppat_d;
            spat_q   <= spat_d;
            ready_q  <= ready_d;
            hb_q     <= hb_d;
            led_q    <= led_d;
            count8_q <= count8_d;
            pos_q    <= pos_d;
            dir_q    <= dir_d;
            duty_q   <= duty_d;
        end
    end

    always_comb begin
        presc_d  = step_tick ? '0 : presc_q + 32'd1;
        hb_d     = hb_q ^ step_tick;
        mode_d   = mode_q;
        pmode_d  = pmode_q;
        pend_d   = pend_q;
        ppat_d   = ppat_q;
        spat_d   = spat_q;
        ready_d  = ready_q;
        count8_d = count8_q;
        pos_d    = pos_q;
        dir_d    = dir_q;
        duty_d   = duty_q;
        if (mode_valid && ready_q) begin
            pend_d  = 1'b1;
            ready_d = 1'b0;
            pmode_d = led_mode_t'(mode_sel);
            ppat_d  = mode_pattern;
        end
        // pend_q is only set from an earlier cycle, so a transfer on the tick waits
        if (step_tick && pend_q) begin
            mode_d   = pmode_q;
            spat_d   = ppat_q;
            pend_d   = 1'b0;
            ready_d  = 1'b1;
            count8_d = '0;
            pos_d    = SCAN_POS_FIRST;
            dir_d    = 1'b0;
            duty_d   = '0;
        end else if (step_tick) begin
            unique case (mode_q)
                BINARY: count8_d = count8_q + 8'd1;
                SCAN: begin
                    if (!dir_q && pos_q == SCAN_POS_LAST) begin
                        dir_d = 1'b1;
                        pos_d = pos_q - 3'd1;
                    end else if (dir_q && pos_q == SCAN_POS_FIRST) begin
                        dir_d = 1'b0;
                        pos_d = pos_q + 3'd1;
                    end else begin
                        pos_d = dir_q ? pos_q - 3'd1 : pos_q + 3'd1;
                    end
                end
                BREATHE: begin
                    if (!dir_q && duty_up >= DUTY_MAX) begin
                        duty_d = DUTY_MAX[PWM_BITS-1:0];
                        dir_d  = 1'b1;
                    end else if (!dir_q) begin
                        duty_d = duty_up[PWM_BITS-1:0];
                    end else if ({1'b0, duty_q} <= DUTY_INC) begin
                        duty_d = '0;
                        dir_d  = 1'b0;
                    end else begin
                        duty_d = duty_q - DUTY_INC[PWM_BITS-1:0];
                    end
                end
                STATIC: ;
            endcase
        end
        if (!locked) begin
            presc_d  = '0;
            hb_d     = 1'b0;
            mode_d   = BINARY;
            pmode_d  = BINARY;
            pend_d   = 1'b0;
            ppat_d   = '0;
            spat_d   = '0;
            ready_d  = 1'b1;
            count8_d = '0;
            pos_d    = SCAN_POS_FIRST;
            dir_d    = 1'b0;
            duty_d   = '0;
        end
    end

    always_comb begin
        led_d = '0;
        unique case (mode_d)
            BINARY:  led_d = count8_d;
            SCAN:    led_d = 8'd1 << pos_d;
            BREATHE: led_d = {LED_COUNT{pwm_on}};
            STATIC:  led_d = spat_d;
        endcase
        if (!locked) led_d = '0;
    end

    assign led        = led_q;
    assign heartbeat  = hb_q;
    assign mode_ready = ready_q;

endmodule
